regwb_arbiter: RTL and testbench

Write-port arbiter and busy-register scoreboard in front of the CPU register bank's single write port. It merges two write sources onto the bank's write port (`we`, `addr_d`, `data_d`):
- the in-order pipeline writeback stage, which always has priority;
- a multi-cycle unit (load/divide) using a valid/ready handshake.

It tracks registers reserved by in-flight multi-cycle operations so decode can stall on RAW/WAW hazards. It also forces a pipeline stall when the multi-cycle unit has been starved for too long.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/regwb_scoreboard.sv | 67 ++++++
 rtl/regwb_arbiter.sv | 145 ++++++++++++++
 tb/tb_regwb_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the register-bank write path: widths and the
// starvation state encoding used by regwb_arbiter.
package cpu_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 16;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } regwb_state_t;

endpackage

// File: rtl/regwb_scoreboard.sv
// Busy-register scoreboard: one busy bit per register (r0 never busy),
// set by reservations, cleared by multi-cycle results, set wins on a tie.
// Optional hazard checker enabled by REGWB_SB_CHECK_EN; without it sb_err is 0.
module regwb_scoreboard
   import cpu_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [REG_ADDR_W-1:0] q_addr_a,
   input  logic [REG_ADDR_W-1:0] q_addr_b,
   output logic                  q_busy_a,
   output logic                  q_busy_b,
   output logic                  sb_err
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // Next busy vector: clear first so a same-register reservation overrides it.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_addr] = 1'b0;
      if (set_en) busy_d[set_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Busy bit storage.
   always_ff @(posedge clk) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign q_busy_a = busy_q[q_addr_a];
   assign q_busy_b = busy_q[q_addr_b];

`ifdef REGWB_SB_CHECK_EN
   logic err_q;
   logic err_d;

   // Sticky error on double reservation, clear of an idle register, or WAW from writeback.
   always_comb begin
      err_d = err_q;
      if (set_en && busy_q[set_addr] && !(clr_en && (clr_addr == set_addr))) err_d = 1'b1;
      if (clr_en && (clr_addr != '0) && !busy_q[clr_addr])                    err_d = 1'b1;
      if (wb_we && busy_q[wb_addr])                                            err_d = 1'b1;
   end

   // Error flag register.
   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign sb_err = err_q;
`else
   logic unused_chk;
   assign unused_chk = ^{wb_we, wb_addr};
   assign sb_err     = 1'b0;
`endif

endmodule

// File: rtl/regwb_arbiter.sv
// Write-port arbiter for the register bank: pipeline writeback has absolute
// priority, the multi-cycle unit fills idle slots and forces a stall when
// starved for STARVE_LIMIT consecutive cycles.
// Optional scoreboard checking: define REGWB_SB_CHECK_EN.
module regwb_arbiter
   import cpu_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  mu_valid,
   output logic                  mu_ready,
   input  logic [REG_ADDR_W-1:0] mu_addr,
   input  logic [DATA_W-1:0]     mu_data,
   input  logic                  rsv_valid,
   input  logic [REG_ADDR_W-1:0] rsv_addr,
   input  logic [REG_ADDR_W-1:0] q_addr_a,
   input  logic [REG_ADDR_W-1:0] q_addr_b,
   output logic                  q_busy_a,
   output logic                  q_busy_b,
   output logic                  stall_req,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0]     rf_data,
   output logic                  sb_err
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   logic                  mu_xfer;
   logic                  rf_we_q,   rf_we_d;
   logic [REG_ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0]     rf_data_q, rf_data_d;
   regwb_state_t          state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  stall_q;

   assign mu_ready = !wb_we;
   assign mu_xfer  = mu_valid && mu_ready;
   assign cnt_inc  = cnt_q + 1'b1;

   // Grant mux: writeback first, then the multi-cycle result; address/data hold when idle.
   always_comb begin
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (wb_we) begin
         rf_we_d   = 1'b1;
         rf_addr_d = wb_addr;
         rf_data_d = wb_data;
      end else if (mu_xfer) begin
         rf_we_d   = 1'b1;
         rf_addr_d = mu_addr;
         rf_data_d = mu_data;
      end
   end

   // Registered write port toward the bank.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else begin
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
      end
   end

   // Starvation tracker: counts consecutive refused cycles and holds the stall until mu drains.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         stall_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mu_valid && !mu_ready) begin
                  cnt_q <= 4'd1;
                  if (LIMIT_C == 4'd1) begin
                     state_q <= FORCE;
                     stall_q <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (mu_xfer || !mu_valid) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_inc;
                  if (cnt_inc == LIMIT_C) begin
                     state_q <= FORCE;
                     stall_q <= 1'b1;
                  end
               end
            end
            FORCE: begin
               // A withdrawn mu request also releases the stall so the pipeline cannot deadlock.
               if (mu_xfer || !mu_valid) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  stall_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               stall_q <= 1'b0;
            end
         endcase
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_addr   = rf_addr_q;
   assign rf_data   = rf_data_q;
   assign stall_req = stall_q;

   regwb_scoreboard u_sb (
      .clk      (clk),
      .reset    (reset),
      .set_en   (rsv_valid),
      .set_addr (rsv_addr),
      .clr_en   (mu_xfer),
      .clr_addr (mu_addr),
      .wb_we    (wb_we),
      .wb_addr  (wb_addr),
      .q_addr_a (q_addr_a),
      .q_addr_b (q_addr_b),
      .q_busy_a (q_busy_a),
      .q_busy_b (q_busy_b),
      .sb_err   (sb_err)
   );

endmodule

// File: tb/tb_regwb_arbiter.sv
// Bench for regwb_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural model of the write port and busy table.
module tb_regwb_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;
   logic        mu_valid;
   logic        mu_ready;
   logic [3:0]  mu_addr;
   logic [31:0] mu_data;
   logic        rsv_valid;
   logic [3:0]  rsv_addr;
   logic [3:0]  q_addr_a;
   logic [3:0]  q_addr_b;
   logic        q_busy_a;
   logic        q_busy_b;
   logic        stall_req;
   logic        rf_we;
   logic [3:0]  rf_addr;
   logic [31:0] rf_data;
   logic        sb_err;

   int n_total = 0;
   int n_bad   = 0;

   // reference model state
   bit [15:0] m_busy;
   bit        m_rf_we;
   bit [3:0]  m_rf_addr;
   bit [31:0] m_rf_data;
   bit        m_stall;
   int        m_run;
   bit        m_err;

   always #5 clk = ~clk;

   regwb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk       (clk),
      .reset     (rst),
      .wb_we     (wb_we),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .mu_valid  (mu_valid),
      .mu_ready  (mu_ready),
      .mu_addr   (mu_addr),
      .mu_data   (mu_data),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .q_addr_a  (q_addr_a),
      .q_addr_b  (q_addr_b),
      .q_busy_a  (q_busy_a),
      .q_busy_b  (q_busy_b),
      .stall_req (stall_req),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data),
      .sb_err    (sb_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      rst       = 1'b0;
      wb_we     = 1'b0;
      wb_addr   = 4'd0;
      wb_data   = 32'd0;
      mu_valid  = 1'b0;
      mu_addr   = 4'd0;
      mu_data   = 32'd0;
      rsv_valid = 1'b0;
      rsv_addr  = 4'd0;
   endtask

   task automatic model_reset();
      m_busy    = '0;
      m_rf_we   = 1'b0;
      m_rf_addr = '0;
      m_rf_data = '0;
      m_stall   = 1'b0;
      m_run     = 0;
      m_err     = 1'b0;
   endtask

   // One clock of the specified behaviour, using the inputs present at the edge.
   task automatic model_step();
      bit xfer;
      xfer = mu_valid && !wb_we;
      if (rst) begin
         model_reset();
      end else begin
         if (rsv_valid && m_busy[rsv_addr] && !(xfer && mu_addr == rsv_addr)) m_err = 1'b1;
         if (xfer && mu_addr != 0 && !m_busy[mu_addr])                       m_err = 1'b1;
         if (wb_we && m_busy[wb_addr])                                        m_err = 1'b1;
         if (wb_we) begin
            m_rf_we = 1'b1; m_rf_addr = wb_addr; m_rf_data = wb_data;
         end else if (xfer) begin
            m_rf_we = 1'b1; m_rf_addr = mu_addr; m_rf_data = mu_data;
         end else begin
            m_rf_we = 1'b0;
         end
         if (xfer) m_busy[mu_addr] = 1'b0;
         if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
         if (m_stall) begin
            if (xfer) begin
               m_stall = 1'b0;
               m_run   = 0;
            end
         end else if (mu_valid && wb_we) begin
            m_run++;
            if (m_run >= LIMIT) m_stall = 1'b1;
         end else begin
            m_run = 0;
         end
      end
   endtask

   // Check combinational outputs, clock once, then check registered outputs.
   task automatic cycle();
      bit exp_err;
      #1;
      chk("mu_ready", mu_ready, !wb_we);
      chk("q_busy_a", q_busy_a, m_busy[q_addr_a]);
      chk("q_busy_b", q_busy_b, m_busy[q_addr_b]);
      @(posedge clk);
      model_step();
      #1;
      chk("rf_we", rf_we, m_rf_we);
      chk("rf_addr", rf_addr, m_rf_addr);
      chk("rf_data", rf_data, m_rf_data);
      chk("stall_req", stall_req, m_stall);
`ifdef REGWB_SB_CHECK_EN
      exp_err = m_err;
`else
      exp_err = 1'b0;
`endif
      chk("sb_err", sb_err, exp_err);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      idle_inputs();
      q_addr_a = 4'd0;
      q_addr_b = 4'd0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      chk("reset_rf_we", rf_we, 1'b0);
      chk("reset_rf_addr", rf_addr, 4'd0);
      chk("reset_rf_data", rf_data, 32'd0);
      chk("reset_stall", stall_req, 1'b0);
      chk("reset_busy", q_busy_a, 1'b0);
      chk("reset_err", sb_err, 1'b0);
      rst = 1'b0;

      // pipeline write
      wb_we = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEADBEEF;
      cycle();
      chk("pipe_we", rf_we, 1'b1);
      chk("pipe_addr", rf_addr, 4'd5);
      chk("pipe_data", rf_data, 32'hDEADBEEF);
      idle_inputs();
      cycle();
      chk("pipe_we_off", rf_we, 1'b0);
      chk("pipe_hold", rf_data, 32'hDEADBEEF);

      // contention: writeback wins, mu goes when wb drops
      wb_we = 1'b1; wb_addr = 4'd4; wb_data = 32'h1111_2222;
      mu_valid = 1'b1; mu_addr = 4'd7; mu_data = 32'h7777_0007;
      #1 chk("cont_refused", mu_ready, 1'b0);
      cycle();
      chk("cont_wb_addr", rf_addr, 4'd4);
      wb_we = 1'b0;
      cycle();
      chk("cont_mu_addr", rf_addr, 4'd7);
      chk("cont_mu_data", rf_data, 32'h7777_0007);
      do_reset();

      // scoreboard timing
      q_addr_a = 4'd3; q_addr_b = 4'd0;
      rsv_valid = 1'b1; rsv_addr = 4'd3;
      cycle();
      idle_inputs();
      chk("sb_busy_c1", q_busy_a, 1'b1);
      repeat (4) cycle();
      mu_valid = 1'b1; mu_addr = 4'd3; mu_data = 32'hCAFE_0003;
      #1 chk("sb_busy_c5", q_busy_a, 1'b1);
      cycle();
      idle_inputs();
      chk("sb_busy_c6", q_busy_a, 1'b0);
      chk("sb_rf_c6", rf_addr, 4'd3);
      chk("sb_we_c6", rf_we, 1'b1);
      rsv_valid = 1'b1; rsv_addr = 4'd3;
      cycle();
      mu_valid = 1'b1; mu_addr = 4'd3; rsv_valid = 1'b1; rsv_addr = 4'd3;
      cycle();
      idle_inputs();
      chk("sb_set_wins", q_busy_a, 1'b1);
      cycle();
      do_reset();

      // starvation then release
      wb_we = 1'b1; wb_addr = 4'd1; mu_valid = 1'b1; mu_addr = 4'd8; mu_data = 32'h88;
      for (int i = 0; i < 4; i++) begin
         wb_data = 32'h100 + i;
         cycle();
         if (i < 3) chk("starve_early", stall_req, 1'b0);
      end
      chk("starve_c4", stall_req, 1'b1);
      wb_we = 1'b0;
      cycle();
      chk("starve_c5", stall_req, 1'b0);
      chk("starve_mu_addr", rf_addr, 4'd8);
      do_reset();

      // reset in the middle of FORCE
      q_addr_a = 4'd9;
      rsv_valid = 1'b1; rsv_addr = 4'd9;
      wb_we = 1'b1; wb_addr = 4'd2; mu_valid = 1'b1; mu_addr = 4'd9; mu_data = 32'h99;
      cycle();
      rsv_valid = 1'b0;
      repeat (3) cycle();
      chk("force_before_rst", stall_req, 1'b1);
      chk("force_busy", q_busy_a, 1'b1);
      rst = 1'b1; wb_we = 1'b0;
      cycle();
      chk("rst_force_stall", stall_req, 1'b0);
      chk("rst_force_we", rf_we, 1'b0);
      chk("rst_force_busy", q_busy_a, 1'b0);
      rst = 1'b0; wb_we = 1'b1; mu_addr = 4'd0;
      repeat (3) cycle();
      chk("rst_cnt_cleared", stall_req, 1'b0);
      do_reset();

      // r0 is never reserved; double reservation flags an error when checking is built in
      q_addr_a = 4'd0; q_addr_b = 4'd2;
      rsv_valid = 1'b1; rsv_addr = 4'd0;
      cycle();
      chk("r0_not_busy", q_busy_a, 1'b0);
      rsv_addr = 4'd2;
      cycle();
      cycle();
      idle_inputs();
      repeat (3) cycle();
`ifdef REGWB_SB_CHECK_EN
      chk("err_held", sb_err, 1'b1);
`endif
      do_reset();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         rst       = ($urandom_range(0, 79) == 0);
         rsv_valid = ($urandom_range(0, 9) < 3);
         rsv_addr  = 4'($urandom_range(0, 15));
         wb_addr   = 4'($urandom_range(0, 15));
         wb_data   = $urandom;
         mu_data   = $urandom;
         q_addr_a  = 4'($urandom_range(0, 15));
         q_addr_b  = 4'($urandom_range(0, 15));
         if (m_stall) begin
            wb_we    = 1'b0;
            mu_valid = 1'b1;
         end else begin
            wb_we    = ($urandom_range(0, 9) < 6);
            mu_valid = ($urandom_range(0, 9) < 5);
         end
         if (mu_valid && ($urandom_range(0, 3) != 0)) begin
            mu_addr = 4'($urandom_range(0, 15));
            for (int k = 1; k < 16; k++) begin
               if (m_busy[k] && $urandom_range(0, 1) == 1) mu_addr = 4'(k);
            end
         end else begin
            mu_addr = 4'($urandom_range(0, 15));
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
